// File: rtl/rv32i_types.sv
// Shared execute-stage types: multiply/divide op codes and unit FSM states.
package rv32i_types;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic md_rs1_signed(md_op_t op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_rs2_signed(md_op_t op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the muldiv datapath: BITS_PER_CYCLE shift-add multiply
// steps or BITS_PER_CYCLE restoring divide steps on a {hi, lo} accumulator.
module md_iter_step #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                i_is_div,
  input  logic [2*XLEN-1:0]   i_acc,
  input  logic [XLEN-1:0]     i_opnd,
  output logic [2*XLEN-1:0]   o_acc
);

  localparam int unsigned MW = XLEN + BITS_PER_CYCLE;

  logic [MW-1:0]     w_hi_sum;
  logic [2*XLEN-1:0] w_mul_acc;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN:0]     w_trial;

  // Multiply: hi += multiplicand * lo[B-1:0], then shift {hi, lo} right by B
  always_comb begin
    w_hi_sum = {{BITS_PER_CYCLE{1'b0}}, i_acc[2*XLEN-1:XLEN]};
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      if (i_acc[j]) begin
        w_hi_sum = w_hi_sum + (MW'(i_opnd) << j);
      end
    end
    w_mul_acc = {w_hi_sum, i_acc[XLEN-1:BITS_PER_CYCLE]};
  end

  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    w_rem   = i_acc[2*XLEN-1:XLEN];
    w_quo   = i_acc[XLEN-1:0];
    w_trial = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      w_trial = {w_rem, w_quo[XLEN-1]};
      w_quo   = {w_quo[XLEN-2:0], 1'b0};
      if (w_trial >= {1'b0, i_opnd}) begin
        w_trial  = w_trial - {1'b0, i_opnd};
        w_quo[0] = 1'b1;
      end
      w_rem = w_trial[XLEN-1:0];
    end
  end

  assign o_acc = i_is_div ? {w_rem, w_quo} : w_mul_acc;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply-divide unit for the execute stage:
// valid/ready request in, N = XLEN/BITS_PER_CYCLE iterations, sign fix, tagged result out.
module ex_muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr,
  output logic            o_busy
);

  import rv32i_types::*;

  localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  md_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_opnd;
  logic [XLEN-1:0]    r_res;
  logic [4:0]         r_rd;
  md_op_t             r_op;
  logic               r_neg_a;
  logic               r_neg_b;

  md_op_t             w_op;
  logic [XLEN-1:0]    w_min;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [XLEN-1:0]    w_mag_a;
  logic [XLEN-1:0]    w_mag_b;
  logic               w_is_div;
  logic               w_div0;
  logic               w_ovf;
  logic               w_special;
  logic [XLEN-1:0]    w_spec_res;
  logic [2*XLEN-1:0]  w_step_acc;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_quo;
  logic [XLEN-1:0]    w_rem;
  logic [XLEN-1:0]    w_fix_res;

  assign o_ready = (r_state == MD_IDLE);
  assign o_busy  = (r_state != MD_IDLE);

  // Operand decode on the accept edge: signs, magnitudes, special-case divides
  assign w_op      = md_op_t'(i_op);
  assign w_min     = {1'b1, {(XLEN-1){1'b0}}};
  assign w_neg_a   = md_rs1_signed(w_op) & i_a[XLEN-1];
  assign w_neg_b   = md_rs2_signed(w_op) & i_b[XLEN-1];
  assign w_mag_a   = w_neg_a ? (-i_a) : i_a;
  assign w_mag_b   = w_neg_b ? (-i_b) : i_b;
  assign w_is_div  = i_op[2];
  assign w_div0    = w_is_div && (i_b == '0);
  assign w_ovf     = ((w_op == MD_DIV) || (w_op == MD_REM)) && (i_a == w_min) &&
                     (i_b == {XLEN{1'b1}});
  assign w_special = w_div0 || w_ovf;
  // i_op[1] selects the remainder flavour of a divide
  assign w_spec_res = w_div0 ? (i_op[1] ? i_a : {XLEN{1'b1}})
                             : (i_op[1] ? {XLEN{1'b0}} : w_min);

  md_iter_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_is_div (r_op[2]),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc)
  );

  // Sign fix: full-width product negation, quotient/remainder sign rules
  assign w_prod = (r_neg_a ^ r_neg_b) ? (-r_acc) : r_acc;
  assign w_quo  = (r_neg_a ^ r_neg_b) ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_a ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    if (r_op[2]) begin
      w_fix_res = r_op[1] ? w_rem : w_quo;
    end else if (r_op == MD_MUL) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MD_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_res     <= '0;
      r_rd      <= '0;
      r_op      <= MD_MUL;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_rd_addr <= '0;
    end else if (i_flush) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      o_valid <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_valid) begin
            r_op    <= w_op;
            r_rd    <= i_rd_addr;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_cnt   <= '0;
            // divide: lo holds dividend, opnd divisor; multiply: lo multiplier, opnd multiplicand
            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
            if (w_special) begin
              r_res   <= w_spec_res;
              r_state <= MD_DONE;
            end else begin
              r_state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          r_acc <= w_step_acc;
          if (r_cnt == CNT_W'(N - 1)) begin
            r_cnt   <= '0;
            r_state <= MD_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        MD_FIX: begin
          r_res   <= w_fix_res;
          r_state <= MD_DONE;
        end
        MD_DONE: begin
          // first DONE cycle registers the result; afterwards hold until accepted
          if (!o_valid) begin
            o_valid   <= 1'b1;
            o_result  <= r_res;
            o_rd_addr <= r_rd;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            r_state <= MD_IDLE;
          end
        end
        default: begin
          r_state <= MD_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: one instance at BITS_PER_CYCLE=1 and one at 4,
// driven by the same request stream and checked against hand-computed results.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [4:0]  i_rd_addr;
  logic        i_flush;
  logic        i_ready;

  logic        rdy1, vld1, busy1;
  logic [31:0] res1;
  logic [4:0]  rd1;
  logic        rdy4, vld4, busy4;
  logic [31:0] res4;
  logic [4:0]  rd4;

  int n_vec;
  int n_bad;

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy1), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_rd_addr(i_rd_addr), .i_flush(i_flush),
    .o_valid(vld1), .i_ready(i_ready), .o_result(res1), .o_rd_addr(rd1), .o_busy(busy1)
  );

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy4), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_rd_addr(i_rd_addr), .i_flush(i_flush),
    .o_valid(vld4), .i_ready(i_ready), .o_result(res4), .o_rd_addr(rd4), .o_busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    i_op = op; i_a = a; i_b = b; i_rd_addr = rd; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic run_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input bit spec);
    int lat1, lat4;
    logic [31:0] r1, r4;
    logic [4:0]  d1, d4;
    lat1 = -1; lat4 = -1; r1 = '0; r4 = '0; d1 = '0; d4 = '0;
    i_ready = 1'b1;
    issue(op, a, b, rd);
    for (int cyc = 1; cyc <= 200 && (lat1 < 0 || lat4 < 0); cyc++) begin
      @(posedge clk); #1;
      if (lat1 < 0 && vld1) begin lat1 = cyc; r1 = res1; d1 = rd1; end
      if (lat4 < 0 && vld4) begin lat4 = cyc; r4 = res4; d4 = rd4; end
    end
    chk("res_bpc1", idx, 64'(r1), 64'(exp));
    chk("rd_bpc1",  idx, 64'(d1), 64'(rd));
    chk("lat_bpc1", idx, 64'(lat1), spec ? 64'd1 : 64'd34);
    chk("res_bpc4", idx, 64'(r4), 64'(exp));
    chk("rd_bpc4",  idx, 64'(d4), 64'(rd));
    chk("lat_bpc4", idx, 64'(lat4), spec ? 64'd1 : 64'd10);
    @(posedge clk); #1;
    chk("idle_after", idx, {62'd0, rdy1, rdy4}, 64'd3);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; i_valid = 1'b0; i_op = 3'b000; i_a = '0; i_b = '0;
    i_rd_addr = '0; i_flush = 1'b0; i_ready = 1'b1;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 1'b0};
    vecs[2]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'h0000_0005, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 5'd9,  32'h0000_0005, 1'b1};
    vecs[6]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1};
    vecs[7]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1'b1};
    vecs[8]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd13, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{3'b101, 32'h0000_0064, 32'h0000_0007, 5'd14, 32'h0000_000E, 1'b0};
    vecs[11] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 5'd15, 32'h0000_0002, 1'b0};
    vecs[12] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFE, 1'b0};
    vecs[13] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd17, 32'h2345_6780, 1'b0};
    vecs[14] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 5'd18, 32'h0FFF_FFFF, 1'b0};
    vecs[15] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd19, 32'hFFFF_FFFD, 1'b0};
    vecs[16] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd20, 32'h0000_0001, 1'b0};
    vecs[17] = '{3'b110, 32'h0000_0005, 32'h0000_0000, 5'd21, 32'h0000_0005, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 0, {62'd0, rdy1, rdy4}, 64'd3);
    chk("reset_valid", 0, {62'd0, vld1, vld4}, 64'd0);
    chk("reset_busy",  0, {62'd0, busy1, busy4}, 64'd0);
    chk("reset_res",   0, {res1, res4}, 64'd0);
    chk("reset_rd",    0, 64'({rd1, rd4}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NVEC; v++) begin
      run_op(v, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].rd, vecs[v].exp, vecs[v].spec);
    end

    // Backpressure: result held in DONE while i_ready is low
    i_ready = 1'b0;
    issue(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd9);
    for (int c = 0; c < 60 && !vld1; c++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid", 100, 64'(vld1), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_res1", 100 + k, 64'(res1), 64'h2345_6780);
      chk("bp_res4", 100 + k, 64'(res4), 64'h2345_6780);
      chk("bp_hold", 100 + k, {60'd0, vld1, vld4, rdy1, rdy4}, 64'hC);
    end
    chk("bp_rd", 105, 64'(rd1), 64'd9);
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 106, {60'd0, vld1, vld4, rdy1, rdy4}, 64'h3);

    // Asynchronous reset in the middle of CALC, no clock edge in between
    issue(3'b000, 32'h0000_0007, 32'h0000_0005, 5'd4);
    repeat (5) @(posedge clk);
    #1;
    chk("ar_busy", 200, {62'd0, busy1, busy4}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", 201, {62'd0, rdy1, rdy4}, 64'd3);
    chk("ar_valid", 201, {62'd0, vld1, vld4}, 64'd0);
    chk("ar_busy0", 201, {62'd0, busy1, busy4}, 64'd0);
    chk("ar_res",   201, {res1, res4}, 64'd0);
    chk("ar_rd",    201, 64'({rd1, rd4}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(202, 3'b000, 32'h0000_0007, 32'h0000_0005, 5'd4, 32'h0000_0023, 1'b0);

    // Flush after 10 iterations of a DIV; the 4-bit instance is holding its result by then
    i_ready = 1'b0;
    issue(3'b100, 32'h0000_0064, 32'h0000_0007, 5'd12);
    repeat (10) @(posedge clk);
    #1;
    i_flush = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("fl_idle", 300, {60'd0, vld1, vld4, rdy1, rdy4}, 64'h3);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(posedge clk); #1;
        if (vld1 || vld4) seen = 1'b1;
      end
      chk("fl_quiet", 301, 64'(seen), 64'd0);
    end

    // Request coincident with flush is not accepted
    i_op = 3'b000; i_a = 32'h3; i_b = 32'h3; i_rd_addr = 5'd1;
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("fl_noacc", 302, {60'd0, busy1, busy4, rdy1, rdy4}, 64'h3);
    repeat (3) @(posedge clk);
    #1;
    chk("fl_noacc_valid", 303, {62'd0, vld1, vld4}, 64'd0);

    run_op(304, 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 5'd17, 32'h0000_0009, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
